// File: rtl/ip_checksum_ttl.sv
// Snoops the packet bus, checks the IPv4 header checksum, classifies options/TTL, and
// computes the decremented TTL plus the incrementally updated checksum for each packet.
module ip_checksum_ttl #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int INFO_DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  input  logic                  rd_check,
  output logic                  ip_checksum_vld,
  output logic                  ip_checksum_is_good,
  output logic                  ip_hdr_has_options,
  output logic                  ip_ttl_is_good,
  output logic [7:0]            ip_new_ttl,
  output logic [15:0]           ip_new_checksum,
  output logic                  info_fifo_overflow
);

  localparam int DEPTH = 1 << INFO_DEPTH_BITS;
  localparam logic [INFO_DEPTH_BITS:0] DEPTH_C = DEPTH[INFO_DEPTH_BITS:0];

  typedef enum logic [7:0] {
    S_RESYNC   = 8'b0000_0001,
    S_WAIT_HDR = 8'b0000_0010,
    S_WORD1    = 8'b0000_0100,
    S_WORD2    = 8'b0000_1000,
    S_WORD3    = 8'b0001_0000,
    S_WORD4    = 8'b0010_0000,
    S_FINISH   = 8'b0100_0000,
    S_WAIT_EOP = 8'b1000_0000
  } state_t;

  typedef struct packed {
    logic        is_good;
    logic        has_options;
    logic        ttl_good;
    logic [7:0]  new_ttl;
    logic [15:0] new_chk;
  } entry_t;

  state_t      state_q, state_d;
  logic [19:0] acc_q, acc_d;
  logic [7:0]  ver_ihl_q, ver_ihl_d;
  logic [7:0]  ttl_q, ttl_d;
  logic [15:0] chk_q, chk_d;
  logic        eop4_q, eop4_d;
  logic        push;
  entry_t      push_entry;
  entry_t      fin_entry;
  logic        is_eop;

  function automatic logic [19:0] hw_sum(input logic [63:0] w);
    return {4'b0, w[63:48]} + {4'b0, w[47:32]} + {4'b0, w[31:16]} + {4'b0, w[15:0]};
  endfunction

  // End-around carry folds for the header sum and the TTL-adjusted checksum.
  logic [16:0] s1;
  logic [15:0] hdr_sum;
  logic [16:0] c1;
  assign s1      = {1'b0, acc_q[15:0]} + {13'b0, acc_q[19:16]};
  assign hdr_sum = s1[15:0] + {15'b0, s1[16]};
  assign c1      = {1'b0, chk_q} + 17'h00100;

  assign fin_entry.is_good     = (hdr_sum == 16'hFFFF);
  assign fin_entry.has_options = (ver_ihl_q != 8'h45);
  assign fin_entry.ttl_good    = (ttl_q > 8'd1);
  assign fin_entry.new_ttl     = (ttl_q == 8'd0) ? 8'd0 : ttl_q - 8'd1;
  assign fin_entry.new_chk     = c1[15:0] + {15'b0, c1[16]};

  assign is_eop = (in_ctrl != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RESYNC;
      acc_q     <= '0;
      ver_ihl_q <= '0;
      ttl_q     <= '0;
      chk_q     <= '0;
      eop4_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ver_ihl_q <= ver_ihl_d;
      ttl_q     <= ttl_d;
      chk_q     <= chk_d;
      eop4_q    <= eop4_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ver_ihl_d  = ver_ihl_q;
    ttl_d      = ttl_q;
    chk_d      = chk_q;
    eop4_d     = eop4_q;
    push       = 1'b0;
    push_entry = '0;
    case (state_q)
      S_RESYNC: if (in_wr && is_eop) state_d = S_WAIT_HDR;
      S_WAIT_HDR: begin
        if (in_wr && !is_eop) begin
          acc_d   = '0;
          state_d = S_WORD1;
        end
      end
      S_WORD1, S_WORD2, S_WORD3: begin
        if (in_wr) begin
          if (is_eop) begin
            // Truncated header: still one entry per packet, flagged unusable.
            push                   = 1'b1;
            push_entry.has_options = 1'b1;
            state_d                = S_WAIT_HDR;
          end else if (state_q == S_WORD1) begin
            acc_d     = acc_q + {4'b0, in_data[15:0]};
            ver_ihl_d = in_data[15:8];
            state_d   = S_WORD2;
          end else if (state_q == S_WORD2) begin
            acc_d   = acc_q + hw_sum(in_data);
            ttl_d   = in_data[15:8];
            state_d = S_WORD3;
          end else begin
            acc_d   = acc_q + hw_sum(in_data);
            chk_d   = in_data[63:48];
            state_d = S_WORD4;
          end
        end
      end
      S_WORD4: begin
        if (in_wr) begin
          acc_d   = acc_q + {4'b0, in_data[63:48]};
          eop4_d  = is_eop;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        push       = 1'b1;
        push_entry = fin_entry;
        state_d    = eop4_q ? S_WAIT_HDR : S_WAIT_EOP;
      end
      S_WAIT_EOP: if (in_wr && is_eop) state_d = S_WAIT_HDR;
      default: state_d = S_RESYNC;
    endcase
  end

  // ip_checksum_vld is the valid side; rd_check pops the head and is ignored when empty.
  entry_t                   mem_q [DEPTH];
  logic [INFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [INFO_DEPTH_BITS:0]   count_q;
  logic                       pop, full, push_ok, ovf_q;

  assign pop     = rd_check && (count_q != '0);
  assign full    = (count_q == DEPTH_C);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
      ovf_q <= push && full && !pop;
    end
  end

  entry_t head;
  assign ip_checksum_vld     = (count_q != '0);
  assign head                = ip_checksum_vld ? mem_q[rd_ptr_q] : '0;
  assign ip_checksum_is_good = head.is_good;
  assign ip_hdr_has_options  = head.has_options;
  assign ip_ttl_is_good      = head.ttl_good;
  assign ip_new_ttl          = head.new_ttl;
  assign ip_new_checksum     = head.new_chk;
  assign info_fifo_overflow  = ovf_q;

endmodule

// File: tb/tb_ip_checksum_ttl.sv
// Bench for ip_checksum_ttl: packet driver, expected-entry queue filled at send time,
// entries popped and compared as the block presents them.
module tb_ip_checksum_ttl;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        rd_check;
  logic        ip_checksum_vld, ip_checksum_is_good, ip_hdr_has_options, ip_ttl_is_good;
  logic [7:0]  ip_new_ttl;
  logic [15:0] ip_new_checksum;
  logic        info_fifo_overflow;

  ip_checksum_ttl dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .rd_check(rd_check), .ip_checksum_vld(ip_checksum_vld),
    .ip_checksum_is_good(ip_checksum_is_good), .ip_hdr_has_options(ip_hdr_has_options),
    .ip_ttl_is_good(ip_ttl_is_good), .ip_new_ttl(ip_new_ttl),
    .ip_new_checksum(ip_new_checksum), .info_fifo_overflow(info_fifo_overflow)
  );

  // ---------------- clock / reset / monitors ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cyc = -1;
  int mark_cyc = 0;
  int ovf_cnt  = 0;
  logic vld_prev = 1'b0;

  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) begin
    if (ip_checksum_vld && !vld_prev) rise_cyc = cyc;
    vld_prev = ip_checksum_vld;
    if (info_fifo_overflow) ovf_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  wire [26:0] head = {ip_checksum_is_good, ip_hdr_has_options, ip_ttl_is_good,
                      ip_new_ttl, ip_new_checksum};

  logic [26:0] exp_q[$];

  // ---------------- packet builder / drivers ----------------
  logic [63:0] pw [0:15];
  logic [7:0]  pc [0:15];
  int          plen, w4_idx, d0;
  bit          p_early;
  logic [26:0] pexp;

  task automatic build_packet(input logic [7:0] vi, input logic [7:0] ttl,
                              input logic [15:0] chk, input int n_data, input int n_mh,
                              input bit rnd);
    logic [31:0] s;
    logic [16:0] c;
    logic [15:0] newc;
    plen    = n_mh + n_data;
    d0      = n_mh;
    w4_idx  = n_mh + 4;
    p_early = (n_data >= 2) && (n_data <= 4);
    for (int i = 0; i < 16; i++) begin
      pw[i] = {$urandom, $urandom};
      pc[i] = (i < n_mh) ? 8'hFF : 8'h00;
    end
    pc[plen-1] = 8'($urandom_range(1, 255));
    if (!rnd) begin
      pw[d0+1][7:0]   = 8'h00;
      pw[d0+2]        = 64'h0073_0000_4000_4011;
      pw[d0+3]        = 64'hB861_C0A8_0001_C0A8;
      pw[d0+4][63:48] = 16'h00C7;
    end
    pw[d0+1][15:8]  = vi;
    pw[d0+2][15:8]  = ttl;
    pw[d0+3][63:48] = chk;
    if (p_early) begin
      pexp = {3'b010, 8'h00, 16'h0000};
    end else begin
      s = {16'h0, pw[d0+1][15:0]} + {16'h0, pw[d0+4][63:48]};
      for (int k = 0; k < 4; k++)
        s = s + {16'h0, pw[d0+2][16*k +: 16]} + {16'h0, pw[d0+3][16*k +: 16]};
      while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      c    = {1'b0, chk} + 17'h00100;
      newc = c[15:0] + {15'b0, c[16]};
      pexp = {(s[15:0] == 16'hFFFF), (vi != 8'h45), (ttl > 8'd1),
              ((ttl == 8'd0) ? 8'h00 : ttl - 8'd1), newc};
    end
  endtask

  task automatic send_range(input int lo, input int hi, input bit bubbles,
                            input bit pop_after_w4, input bit tail_idle);
    for (int i = lo; i <= hi; i++) begin
      if (bubbles && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_wr = 1'b0; rd_check = 1'b0;
      end
      @(negedge clk);
      in_wr    = 1'b1;
      in_data  = pw[i];
      in_ctrl  = pc[i];
      rd_check = pop_after_w4 && (i == w4_idx + 1);
      if ((!p_early && i == w4_idx) || (p_early && i == plen - 1)) mark_cyc = cyc;
    end
    if (tail_idle) begin
      @(negedge clk);
      in_wr = 1'b0; rd_check = 1'b0;
    end
  endtask

  task automatic send_packet(input logic [7:0] vi, input logic [7:0] ttl,
                             input logic [15:0] chk, input int n_data, input int n_mh,
                             input bit rnd, input bit bubbles, input bit push,
                             input bit tail_idle);
    build_packet(vi, ttl, chk, n_data, n_mh, rnd);
    send_range(0, plen - 1, bubbles, 1'b0, tail_idle);
    if (push) exp_q.push_back(pexp);
  endtask

  task automatic send_random(input bit push);
    logic [7:0] vi;
    vi = ($urandom_range(0, 2) == 0) ? 8'($urandom) : (($urandom_range(0, 1) == 0) ? 8'h45 : 8'h46);
    send_packet(vi, 8'($urandom), 16'($urandom), $urandom_range(2, 9), $urandom_range(1, 2),
                1'b1, 1'b1, push, 1'b1);
  endtask

  task automatic wait_vld(output bit ok);
    int n = 0;
    while (!ip_checksum_vld && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = ip_checksum_vld;
  endtask

  task automatic do_pop();
    @(negedge clk); rd_check = 1'b1;
    @(negedge clk); rd_check = 1'b0;
  endtask

  task automatic drain_one(output bit ok, output logic [26:0] got);
    wait_vld(ok);
    got = head;
    if (ok) do_pop();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (ip_checksum_vld !== 1'b0) begin
      n_fail++; $display("FAIL reset_vld: got=%b required=0", ip_checksum_vld);
    end
    n_checks++;
    if (info_fifo_overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf: got=%b required=0", info_fifo_overflow);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (head !== 27'h0 || ip_checksum_vld !== 1'b0) begin
      n_fail++; $display("FAIL reset_head: got=%h vld=%b required=0", head, ip_checksum_vld);
    end
  endtask

  task automatic test_basic();
    bit ok; logic [26:0] got, e;
    rise_cyc = -1;
    send_packet(8'h45, 8'h40, 16'hB861, 8, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({1'b1, 1'b0, 1'b1, 8'h3F, 16'hB961});
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (rise_cyc - mark_cyc != 2) begin
      n_fail++; $display("FAIL basic_latency: got=%0d required=2", rise_cyc - mark_cyc);
    end
    // Variants of the standard vector; each row is self-derived from the header fields.
    send_packet(8'h45, 8'h40, 16'hB862, 8, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 1'b0, 1'b1, 8'h3F, 16'hB962});
    send_packet(8'h45, 8'h01, 16'hB861, 8, 2, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h00, 16'hB961});
    send_packet(8'h46, 8'h40, 16'hB861, 8, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 1'b1, 1'b1, 8'h3F, 16'hB961});
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      drain_one(ok, got);
      n_checks++;
      if (!ok || got !== e) begin
        n_fail++; $display("FAIL basic_entry: vld=%0b got=%h required=%h", ok, got, e);
      end
    end
    send_packet(8'h45, 8'h40, 16'hFF00, 8, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 1'b0, 1'b1, 8'h3F, 16'h0001});
    send_packet(8'h45, 8'h00, 16'hB861, 8, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h00, 16'hB961});
    send_packet(8'h45, 8'h02, 16'hB861, 8, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 1'b0, 1'b1, 8'h01, 16'hB961});
    send_packet(8'h45, 8'hFF, 16'hB861, 6, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 1'b0, 1'b1, 8'hFE, 16'hB961});
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      drain_one(ok, got);
      n_checks++;
      if (!ok || got !== e) begin
        n_fail++; $display("FAIL variant_entry: vld=%0b got=%h required=%h", ok, got, e);
      end
    end
    n_checks++;
    if (ip_checksum_vld !== 1'b0) begin
      n_fail++; $display("FAIL basic_empty: vld=%b required=0", ip_checksum_vld);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [26:0] got, e;
    ovf_cnt = 0;
    for (int p = 0; p < 5; p++)
      send_packet(8'h45, 8'($urandom), 16'($urandom), 8, 1, 1'b1, 1'b0, (p < 4), 1'b0);
    repeat (4) @(negedge clk);
    in_wr = 1'b0;
    n_checks++;
    if (ovf_cnt != 1) begin
      n_fail++; $display("FAIL b2b_overflow: pulses=%0d required=1", ovf_cnt);
    end
    n_checks++;
    if (!ip_checksum_vld || head !== exp_q[0]) begin
      n_fail++; $display("FAIL b2b_head: vld=%b got=%h required=%h", ip_checksum_vld, head, exp_q[0]);
    end
    // Pop lands in the FINISH cycle of a push while full.
    build_packet(8'h45, 8'($urandom), 16'($urandom), 8, 1, 1'b1);
    send_range(0, plen - 1, 1'b0, 1'b1, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back(pexp);
    repeat (3) @(negedge clk);
    n_checks++;
    if (ovf_cnt != 1 || ip_checksum_vld !== 1'b1) begin
      n_fail++; $display("FAIL b2b_push_pop_full: pulses=%0d vld=%b required 1 and 1", ovf_cnt, ip_checksum_vld);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      drain_one(ok, got);
      n_checks++;
      if (!ok || got !== e) begin
        n_fail++; $display("FAIL b2b_entry: vld=%0b got=%h required=%h", ok, got, e);
      end
    end
    n_checks++;
    if (ip_checksum_vld !== 1'b0) begin
      n_fail++; $display("FAIL b2b_empty: vld=%b required=0", ip_checksum_vld);
    end
  endtask

  task automatic test_short();
    bit ok; logic [26:0] got, e;
    rise_cyc = -1;
    send_packet(8'h45, 8'h40, 16'hB861, 3, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (rise_cyc - mark_cyc != 1) begin
      n_fail++; $display("FAIL short_latency: got=%0d required=1", rise_cyc - mark_cyc);
    end
    send_packet(8'h45, 8'h40, 16'hB861, 8, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    send_packet(8'h45, 8'h40, 16'hB861, 2, 2, 1'b0, 1'b0, 1'b1, 1'b1);
    send_packet(8'h45, 8'h22, 16'h1234, 4, 1, 1'b1, 1'b0, 1'b1, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      drain_one(ok, got);
      n_checks++;
      if (!ok || got !== e) begin
        n_fail++; $display("FAIL short_entry: vld=%0b got=%h required=%h", ok, got, e);
      end
    end
    // Packet ending in word4, next module header driven during FINISH.
    send_packet(8'h45, 8'h40, 16'hB861, 5, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_packet(8'h45, 8'h09, 16'hFF00, 8, 1, 1'b1, 1'b0, 1'b1, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      drain_one(ok, got);
      n_checks++;
      if (!ok || got !== e) begin
        n_fail++; $display("FAIL eop4_entry: vld=%0b got=%h required=%h", ok, got, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [26:0] got, e;
    send_packet(8'h45, 8'h40, 16'hB861, 8, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    build_packet(8'h45, 8'h40, 16'hB861, 8, 1, 1'b0);
    send_range(0, d0 + 2, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    in_wr = 1'b0;
    #1;
    n_checks++;
    if (ip_checksum_vld !== 1'b0 || head !== 27'h0) begin
      n_fail++; $display("FAIL midreset_vld: vld=%b head=%h required 0", ip_checksum_vld, head);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send_range(d0 + 3, plen - 1, 1'b0, 1'b0, 1'b1);
    send_packet(8'h45, 8'h80, 16'h8000, 7, 1, 1'b1, 1'b0, 1'b1, 1'b1);
    e = exp_q.pop_front();
    drain_one(ok, got);
    n_checks++;
    if (!ok || got !== e) begin
      n_fail++; $display("FAIL midreset_entry: vld=%0b got=%h required=%h", ok, got, e);
    end
    n_checks++;
    if (ip_checksum_vld !== 1'b0) begin
      n_fail++; $display("FAIL midreset_count: vld=%b required=0 (one entry only)", ip_checksum_vld);
    end
  endtask

  task automatic test_random();
    bit ok; logic [26:0] got, e;
    ovf_cnt = 0;
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 3; p++) send_random(1'b1);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        drain_one(ok, got);
        n_checks++;
        if (!ok || got !== e) begin
          n_fail++; $display("FAIL random_entry: vld=%0b got=%h required=%h", ok, got, e);
        end
      end
    end
    n_checks++;
    if (ovf_cnt != 0) begin
      n_fail++; $display("FAIL random_overflow: pulses=%0d required=0", ovf_cnt);
    end
  endtask

  initial begin
    reset    = 1'b0;
    in_wr    = 1'b0;
    in_data  = '0;
    in_ctrl  = '0;
    rd_check = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    // Leaves RESYNC on the first word with nonzero control.
    @(negedge clk); in_wr = 1'b1; in_ctrl = 8'h01; in_data = '0;
    @(negedge clk); in_wr = 1'b0; in_ctrl = 8'h00;
    test_basic();
    test_back_to_back();
    test_short();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
